sub32_seq: RTL
==============

Name: sub32_seq

Overview:
- Multi-cycle 32-bit two's-complement subtractor. It is the inverse operation to the ALU's combinational ripple adder.
- Computes out = a - b - bin one SLICE_W-bit slice per clock, least-significant slice first, with the borrow carried in a register between cycles.
- Sits beside the adder in the alu32 datapath and trades latency for a small slice datapath.
- Uses a start/busy/done handshake toward the ALU controller.

Parameters:
W, 32, operand width in bits.
SLICE_W, 8, bits processed per cycle. Must divide W; legal values 1, 2, 4, 8, 16, 32.
N (localparam), W/SLICE_W, number of slice cycles.

Ports:
m_clock  in  1  clock; all state changes on the rising edge.
p_reset  in  1  synchronous, active-high reset.
a  in  W  minuend; sampled only on an accepted start.
b  in  W  subtrahend; sampled only on an accepted start.
bin  in  1  borrow-in; sampled only on an accepted start.
start  in  1  request a new operation.
busy  out  1  high while slices are being processed.
done  out  1  one-cycle pulse; results valid from this cycle on.
out  out  W  difference a - b - bin, modulo 2^W.
bout  out  1  borrow-out; 1 iff unsigned a < b + bin.
ov  out  1  signed overflow: (a[W-1] ^ b[W-1]) & (out[W-1] ^ a[W-1]).
zero  out  1  1 iff out == 0.

Behaviour:
- Clock and reset: one clock, m_clock. p_reset is synchronous and active-high. No asynchronous logic.
- Reset: state IDLE, slice index 0, and busy, done, out, bout, ov, zero all 0. Internal operand and borrow registers are cleared.
- Reset wins over every other input in the same cycle. Reset while in RUN aborts the operation and produces no done pulse.
- State IDLE: start=1 latches a, b and bin into internal registers, clears the slice index, and goes to RUN.
- State RUN: busy=1. Each cycle, slice k computes {nb, d} = a_k + ~b_k + !borrow.
  - borrow is seeded with bin.
  - nb is the inverted slice carry; it becomes the next borrow.
  - d is written to out[k*SLICE_W +: SLICE_W].
- After slice N-1: bout = final borrow, and ov and zero are computed from the full out; go to DONE.
- Latency: start sampled at edge t gives done=1 in the cycle after edge t+N. With defaults that is 4 cycles.
- State DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
  - start=1 in DONE is accepted and goes straight to RUN, so operations can run back-to-back with no idle cycle.
- start while in RUN is ignored; no queueing. The operand registers are not disturbed.
- out, bout, ov and zero change only during RUN. During RUN, out is partially updated and must not be used.
- After done, the results hold until the next accepted start or a reset.
- SLICE_W=W degenerates to N=1, giving single-cycle latency through the same FSM.
- Arithmetic: all slice sums are SLICE_W+1 bits wide, so there is no sign extension. Results wrap modulo 2^W.

Optional Feature:
SUB32_SEQ_CMP_EN
- Defined: adds two outputs, ltu (= bout) and lt (= out[W-1] ^ ov, i.e. signed a < b + bin). Both are registered with the other flags, reset to 0, and valid from done onward.
- Undefined: the lt and ltu ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package alu32_pkg holds:
  - the W default;
  - the SLICE_W default;
  - the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the flag bit positions, so this block and the adder share one status format.
- One sub-module, sub_slice: combinational SLICE_W-wide subtract.
  - Inputs: x, y, borrow_in.
  - Outputs: d, borrow_out.
  - Instantiated once inside sub32_seq.

Test Plan:
- Defaults, a=5, b=3, bin=0, start pulse: done exactly 4 cycles later; out=0x00000002, bout=0, ov=0, zero=0. busy is high for those 4 cycles and low at done.
- a=0, b=1: out=0xFFFFFFFF, bout=1, ov=0. Then a=0x80000000, b=1: out=0x7FFFFFFF, bout=0, ov=1.
- a=0x7FFFFFFF, b=0xFFFFFFFF: out=0x80000000, bout=1, ov=1. a=10, b=3, bin=1: out=6. a=b=0x12345678: zero=1.
- Operand change during RUN: start plus a new a/b 2 cycles after an accepted start is ignored; the result still equals the first operation. start in the DONE cycle with a=9, b=4 produces out=5 done 4 cycles later.
- p_reset for one cycle during RUN (slice 2): the next cycle shows all outputs 0, state IDLE, and no done pulse. A subsequent start works normally.
- SLICE_W=1 (N=32) and SLICE_W=32 (N=1): random-vector comparison against a - b - bin with latency N. With SUB32_SEQ_CMP_EN, a=-1, b=1 gives lt=1, ltu=0.

Source files
------------

// File: rtl/alu32_pkg.sv
// rtl/alu32_pkg.sv - shared alu32 datapath constants, FSM encoding and status flag layout
//
// Purpose: common definitions for the alu32 adder and the sequential
// subtractor so both blocks agree on widths, FSM encoding and flag format.
// Ports: none (package).
package alu32_pkg;

    localparam int ALU_W       = 32;
    localparam int ALU_SLICE_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bit positions of the status word shared by the adder and subtractor.
    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_OV     = 1;
    localparam int FLAG_BORROW = 2;
    localparam int FLAG_LT     = 3;
    localparam int FLAG_LTU    = 4;
    localparam int FLAG_W      = 5;

    typedef logic [FLAG_W-1:0] alu_flags_t;

    // Signed overflow of a - b: operand signs differ and the result sign
    // disagrees with the minuend.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/sub32_seq_if.sv
// rtl/sub32_seq_if.sv - start/busy/done handshake and result bus of the sequential subtractor
//
// Purpose: bundles operands, handshake and result flags between the ALU
// controller (master) and sub32_seq (slave).
// Signals: a, b, bin, start (controller -> subtractor);
//          busy, done, out, bout, ov, zero (subtractor -> controller);
//          lt, ltu only when SUB32_SEQ_CMP_EN is defined.
interface sub32_seq_if
    import alu32_pkg::*;
#(
    parameter int W = ALU_W
);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         bout;
    logic         ov;
    logic         zero;

`ifdef SUB32_SEQ_CMP_EN
    logic         lt;
    logic         ltu;

    modport master (output a, b, bin, start,
                    input  busy, done, out, bout, ov, zero, lt, ltu);
    modport slave  (input  a, b, bin, start,
                    output busy, done, out, bout, ov, zero, lt, ltu);
`else
    modport master (output a, b, bin, start,
                    input  busy, done, out, bout, ov, zero);
    modport slave  (input  a, b, bin, start,
                    output busy, done, out, bout, ov, zero);
`endif

endinterface

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational SLICE_W-bit subtract slice with borrow chaining
//
// Purpose: {borrow_out, d} from x - y - borrow_in, done as x + ~y + !borrow_in.
// Ports: x, y       slice operands
//        borrow_in  borrow from the less-significant slice
//        d          slice difference
//        borrow_out inverted carry, feeds the next slice
module sub_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               borrow_in,
    output logic [SLICE_W-1:0] d,
    output logic               borrow_out
);

    logic carry;

    // SLICE_W+1 bit sum: the top bit is the carry, never a sign extension.
    assign {carry, d} = {1'b0, x} + {1'b0, ~y} + {{SLICE_W{1'b0}}, ~borrow_in};
    assign borrow_out = ~carry;

endmodule

// File: rtl/sub32_seq.sv
// rtl/sub32_seq.sv - multi-cycle W-bit subtractor, one SLICE_W slice per clock, LSB slice first
//
// Purpose: out = a - b - bin modulo 2^W over N = W/SLICE_W RUN cycles with a
// start/busy/done handshake. Results hold from done until the next accepted start.
// Ports: m_clock  clock, rising edge
//        p_reset  synchronous active-high reset
//        bus      sub32_seq_if.slave: a, b, bin, start in; busy, done, out,
//                 bout, ov, zero out (plus lt, ltu with SUB32_SEQ_CMP_EN)
// Config macro: SUB32_SEQ_CMP_EN adds registered lt/ltu compare outputs.
module sub32_seq
    import alu32_pkg::*;
#(
    parameter int W       = ALU_W,
    parameter int SLICE_W = ALU_SLICE_W
) (
    input  logic       m_clock,
    input  logic       p_reset,
    sub32_seq_if.slave bus
);

    localparam int N     = W / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
    localparam logic [W-1:0]     SLICE_MASK = {W{1'b1}} >> (W - SLICE_W);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [W-1:0]     out_q, out_d;
    logic             bout_q, bout_d;
    logic             ov_q, ov_d;
    logic             zero_q, zero_d;
`ifdef SUB32_SEQ_CMP_EN
    logic             lt_q, lt_d;
    logic             ltu_q, ltu_d;
`endif

    logic [31:0]        slice_base;
    logic [SLICE_W-1:0] slice_x;
    logic [SLICE_W-1:0] slice_y;
    logic [SLICE_W-1:0] slice_d;
    logic               slice_bout;

    assign slice_base = 32'(idx_q) * 32'(SLICE_W);
    assign slice_x    = SLICE_W'(a_q >> slice_base);
    assign slice_y    = SLICE_W'(b_q >> slice_base);

    sub_slice #(
        .SLICE_W(SLICE_W)
    ) u_slice (
        .x         (slice_x),
        .y         (slice_y),
        .borrow_in (borrow_q),
        .d         (slice_d),
        .borrow_out(slice_bout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        out_d    = out_q;
        bout_d   = bout_q;
        ov_d     = ov_q;
        zero_d   = zero_q;
`ifdef SUB32_SEQ_CMP_EN
        lt_d     = lt_q;
        ltu_d    = ltu_q;
`endif

        case (state_q)
            // DONE accepts start like IDLE so operations can run back-to-back.
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    idx_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end

            RUN: begin
                out_d    = (out_q & ~(SLICE_MASK << slice_base))
                         | (W'(slice_d) << slice_base);
                borrow_d = slice_bout;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // Flags are taken from the fully assembled difference.
                    bout_d  = slice_bout;
                    ov_d    = sub_overflow(a_q[W-1], b_q[W-1], out_d[W-1]);
                    zero_d  = (out_d == '0);
`ifdef SUB32_SEQ_CMP_EN
                    ltu_d   = slice_bout;
                    lt_d    = out_d[W-1] ^ sub_overflow(a_q[W-1], b_q[W-1], out_d[W-1]);
`endif
                    idx_d   = '0;
                    state_d = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            out_q    <= '0;
            bout_q   <= 1'b0;
            ov_q     <= 1'b0;
            zero_q   <= 1'b0;
`ifdef SUB32_SEQ_CMP_EN
            lt_q     <= 1'b0;
            ltu_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            out_q    <= out_d;
            bout_q   <= bout_d;
            ov_q     <= ov_d;
            zero_q   <= zero_d;
`ifdef SUB32_SEQ_CMP_EN
            lt_q     <= lt_d;
            ltu_q    <= ltu_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.out  = out_q;
    assign bus.bout = bout_q;
    assign bus.ov   = ov_q;
    assign bus.zero = zero_q;
`ifdef SUB32_SEQ_CMP_EN
    assign bus.lt   = lt_q;
    assign bus.ltu  = ltu_q;
`endif

endmodule
